uart_port: RTL

Memory-mapped UART peripheral on the MCU peripheral bus at $FB14–$FB17, alongside PIO and TMR1. It serialises bytes the CPU writes and deserialises bytes arriving on `rxd`. The byte format is 8N1 with 16× oversampling from a programmable divider. It drives a level interrupt request that the top level merges into the CPU interrupt line, next to the timer request.

---
 rtl/uart_port.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_port.sv
// uart_port: bus-mapped 8N1 UART with 16x oversampling and a level interrupt.
// Define UART_RX_FIFO_EN to replace the single RX holding register with a 4-entry FIFO.
module uart_port #(
  parameter logic [7:0] DEFAULT_BAUD = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] rs,
  input  logic       wren,
  input  logic       rden,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       txd,
  input  logic       rxd,
  output logic       irq
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  logic [3:0] r_ctrl;
  logic [7:0] r_baud, r_baudActive, r_tickCnt;
  logic       r_wrPrev, r_rdPrev;
  logic [1:0] r_rdSel;
  logic [7:0] r_hold;
  logic       r_holdFull, r_overrun, r_frameErr;
  logic       r_rxSync1, r_rxSync2, r_rxPrev;

  txState_t   r_txState, w_txStateNext;
  logic [3:0] r_txTick, w_txTickNext;
  logic [2:0] r_txBit, w_txBitNext;
  logic [7:0] r_txShift, w_txShiftNext;
  logic       w_txLoad;

  rxState_t   r_rxState, w_rxStateNext;
  logic [3:0] r_rxTick, w_rxTickNext;
  logic [2:0] r_rxBit, w_rxBitNext;
  logic [7:0] r_rxShift, w_rxShiftNext;
  logic       w_rxStore, w_rxFrameErr, w_rxOverrun;

  logic       w_tick, w_wrStrobe, w_rdFall, w_pop, w_rxFall;
  logic       w_rxValid, w_txBusy;
  logic [7:0] w_rxData;

  assign w_tick     = (r_tickCnt == r_baudActive);
  assign w_wrStrobe = en & wren & ~r_wrPrev;
  assign w_rdFall   = r_rdPrev & ~(en & rden);
  assign w_pop      = w_rdFall & (r_rdSel == 2'd0) & w_rxValid;
  assign w_rxFall   = r_rxPrev & ~r_rxSync2;
  assign w_txBusy   = (r_txState != TX_IDLE);

  // The divisor is latched at each reload so a BAUD write never truncates the running tick period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tickCnt    <= 8'd0;
      r_baudActive <= DEFAULT_BAUD;
    end else if (w_tick) begin
      r_tickCnt    <= 8'd0;
      r_baudActive <= r_baud;
    end else begin
      r_tickCnt    <= r_tickCnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPrev   <= 1'b0;
      r_rdPrev   <= 1'b0;
      r_rdSel    <= 2'd0;
      r_ctrl     <= 4'h0;
      r_baud     <= DEFAULT_BAUD;
      r_hold     <= 8'h00;
      r_holdFull <= 1'b0;
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
      r_rxSync1  <= 1'b1;
      r_rxSync2  <= 1'b1;
      r_rxPrev   <= 1'b1;
    end else begin
      r_wrPrev  <= en & wren;
      r_rdPrev  <= en & rden;
      r_rxSync1 <= rxd;
      r_rxSync2 <= r_rxSync1;
      r_rxPrev  <= r_rxSync2;
      if (en & rden)
        r_rdSel <= rs;
      if (w_txLoad)
        r_holdFull <= 1'b0;
      if (w_wrStrobe) begin
        case (rs)
          2'd0: if (!r_holdFull) begin
            r_hold     <= data_in;
            r_holdFull <= 1'b1;
          end
          2'd1: begin
            if (data_in[3]) r_overrun  <= 1'b0;
            if (data_in[4]) r_frameErr <= 1'b0;
          end
          2'd2: r_ctrl <= data_in[3:0];
          default: r_baud <= data_in;
        endcase
      end
      if (w_rxOverrun)  r_overrun  <= 1'b1;
      if (w_rxFrameErr) r_frameErr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txState <= TX_IDLE;
      r_txTick  <= 4'd0;
      r_txBit   <= 3'd0;
      r_txShift <= 8'h00;
      r_rxState <= RX_IDLE;
      r_rxTick  <= 4'd0;
      r_rxBit   <= 3'd0;
      r_rxShift <= 8'h00;
    end else begin
      r_txState <= w_txStateNext;
      r_txTick  <= w_txTickNext;
      r_txBit   <= w_txBitNext;
      r_txShift <= w_txShiftNext;
      r_rxState <= w_rxStateNext;
      r_rxTick  <= w_rxTickNext;
      r_rxBit   <= w_rxBitNext;
      r_rxShift <= w_rxShiftNext;
    end
  end

  // Every TX state spans 16 ticks; a cleared tx_en only blocks the next load.
  always_comb begin
    w_txStateNext = r_txState;
    w_txTickNext  = r_txTick;
    w_txBitNext   = r_txBit;
    w_txShiftNext = r_txShift;
    w_txLoad      = 1'b0;
    if (w_tick) begin
      case (r_txState)
        TX_IDLE: if (r_ctrl[0] && r_holdFull) begin
          w_txLoad      = 1'b1;
          w_txShiftNext = r_hold;
          w_txTickNext  = 4'd0;
          w_txBitNext   = 3'd0;
          w_txStateNext = TX_START;
        end
        TX_START: begin
          w_txTickNext = r_txTick + 4'd1;
          if (r_txTick == 4'd15) w_txStateNext = TX_DATA;
        end
        TX_DATA: begin
          w_txTickNext = r_txTick + 4'd1;
          if (r_txTick == 4'd15) begin
            w_txShiftNext = {1'b0, r_txShift[7:1]};
            w_txBitNext   = r_txBit + 3'd1;
            if (r_txBit == 3'd7) w_txStateNext = TX_STOP;
          end
        end
        default: begin
          w_txTickNext = r_txTick + 4'd1;
          if (r_txTick == 4'd15) w_txStateNext = TX_IDLE;
        end
      endcase
    end
  end

  assign txd = (r_txState == TX_START) ? 1'b0 :
               (r_txState == TX_DATA)  ? r_txShift[0] : 1'b1;

  // Start bit is confirmed at its midpoint, then each later bit is sampled one bit time apart.
  always_comb begin
    w_rxStateNext = r_rxState;
    w_rxTickNext  = r_rxTick;
    w_rxBitNext   = r_rxBit;
    w_rxShiftNext = r_rxShift;
    w_rxStore     = 1'b0;
    w_rxFrameErr  = 1'b0;
    if (!r_ctrl[1]) begin
      w_rxStateNext = RX_IDLE;
      w_rxTickNext  = 4'd0;
      w_rxBitNext   = 3'd0;
    end else begin
      case (r_rxState)
        RX_IDLE: if (w_rxFall) begin
          w_rxStateNext = RX_START;
          w_rxTickNext  = 4'd0;
        end
        RX_START: if (w_tick) begin
          w_rxTickNext = r_rxTick + 4'd1;
          if (r_rxTick == 4'd7) begin
            w_rxTickNext = 4'd0;
            w_rxBitNext  = 3'd0;
            w_rxStateNext = r_rxSync2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: if (w_tick) begin
          w_rxTickNext = r_rxTick + 4'd1;
          if (r_rxTick == 4'd15) begin
            w_rxShiftNext = {r_rxSync2, r_rxShift[7:1]};
            w_rxBitNext   = r_rxBit + 3'd1;
            if (r_rxBit == 3'd7) w_rxStateNext = RX_STOP;
          end
        end
        default: if (w_tick) begin
          w_rxTickNext = r_rxTick + 4'd1;
          if (r_rxTick == 4'd15) begin
            w_rxStore     = r_rxSync2;
            w_rxFrameErr  = ~r_rxSync2;
            w_rxStateNext = RX_IDLE;
          end
        end
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wPtr, r_rPtr;
  logic [2:0] r_count;
  logic       w_push;

  assign w_rxOverrun = w_rxStore & (r_count == 3'd4) & ~w_pop;
  assign w_push      = w_rxStore & ~w_rxOverrun;
  assign w_rxValid   = (r_count != 3'd0);
  assign w_rxData    = r_fifo[r_rPtr];

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wPtr] <= r_rxShift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wPtr  <= 2'd0;
      r_rPtr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_wPtr <= r_wPtr + 2'd1;
      if (w_pop)  r_rPtr <= r_rPtr + 2'd1;
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_push) r_count <= r_count - 3'd1;
    end
  end
`else
  logic [7:0] r_rxData;
  logic       r_rxValid;

  // A pop in the same cycle as a store frees the register first, so no overrun is flagged.
  assign w_rxOverrun = w_rxStore & r_rxValid & ~w_pop;
  assign w_rxValid   = r_rxValid;
  assign w_rxData    = r_rxData;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxData  <= 8'h00;
      r_rxValid <= 1'b0;
    end else begin
      if (w_pop) r_rxValid <= 1'b0;
      if (w_rxStore && !w_rxOverrun) begin
        r_rxData  <= r_rxShift;
        r_rxValid <= 1'b1;
      end
    end
  end
`endif

  always_comb begin
    data_out = 8'h00;
    case (rs)
      2'd0:    data_out = w_rxData;
      2'd1:    data_out = {3'b000, r_frameErr, r_overrun, r_holdFull, w_txBusy, w_rxValid};
      2'd2:    data_out = {4'h0, r_ctrl};
      default: data_out = r_baud;
    endcase
  end

  assign irq = (r_ctrl[2] & w_rxValid) | (r_ctrl[3] & ~r_holdFull);

endmodule
